// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the stall/flush sequencer: the FSM state encodings,
// also used by the trace/debug monitor to decode ctrlState.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        IWAIT = 2'd2,
        HALT  = 2'd3
    } ctrlState_e;

    localparam int STATE_W = 2;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clrN,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled cycles, stick at the maximum value, clear on reset
    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer: turns hazard, memory-stall, redirect and
// halt indications into per-stage write enables and bubble controls.
import pipe_stall_ctrl_pkg::*;

module pipe_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             loadHazard,
    input  logic             iMemStall,
    input  logic             iMemDone,
    input  logic             dMemStall,
    input  logic             dMemDone,
    input  logic             redirectExMem,
    input  logic             haltMemWb,
    output logic             writePc,
    output logic             writeIfId,
    output logic             writeIdEx,
    output logic             writeExMem,
    output logic             writeMemWb,
    output logic             flushIfId,
    output logic             controlZeroIdEx,
    output logic             halted,
    output logic [1:0]       ctrlState,
    output logic [CNT_W-1:0] stallCycles
);

    ctrlState_e state, stateNext;
    logic       iPend, iPendNext;
    logic       discard, discardNext;
    logic       frozen;
    logic       iStalled;
    logic       countEn;

    // State and sticky flags; reset clears everything without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            iPend   <= 1'b0;
            discard <= 1'b0;
        end else begin
            state   <= stateNext;
            iPend   <= iPendNext;
            discard <= discardNext;
        end
    end

    // Next-state logic plus iPend/discard bookkeeping for the outstanding fetch
    always_comb begin
        stateNext   = state;
        iPendNext   = iPend;
        discardNext = discard;
        case (state)
            RUN: begin
                if (haltMemWb) begin
                    stateNext = HALT;
                end else if (dMemStall) begin
                    stateNext = DWAIT;
                    if (iMemStall) iPendNext = 1'b1;
                end else if (iMemStall) begin
                    stateNext = IWAIT;
                end
            end
            DWAIT: begin
                if (dMemDone) stateNext = (iPend && !iMemDone) ? IWAIT : RUN;
            end
            IWAIT: begin
                if (iMemDone) begin
                    stateNext = RUN;
                end else if (dMemStall) begin
                    stateNext = DWAIT;
                    iPendNext = 1'b1;
                end
            end
            HALT: stateNext = HALT;
            default: stateNext = RUN;
        endcase
        if (iMemDone) begin
            iPendNext   = 1'b0;
            discardNext = 1'b0;
        end else if (redirectExMem && (state == IWAIT || iPend)) begin
            discardNext = 1'b1;
        end
    end

    assign frozen   = (state == DWAIT) || (state == RUN && dMemStall);
    assign iStalled = (state == IWAIT) || (state == RUN && iMemStall);

    // Mealy decode of stage enables and bubble controls from state, flags and inputs
    always_comb begin
        writePc         = 1'b1;
        writeIfId       = 1'b1;
        writeIdEx       = 1'b1;
        writeExMem      = 1'b1;
        writeMemWb      = 1'b1;
        flushIfId       = 1'b0;
        controlZeroIdEx = 1'b0;
        halted          = 1'b0;
        if (!rst_n) begin
            writePc    = 1'b0;
            writeIfId  = 1'b0;
            writeIdEx  = 1'b0;
            writeExMem = 1'b0;
            writeMemWb = 1'b0;
        end else if (state == HALT) begin
            writePc    = 1'b0;
            writeIfId  = 1'b0;
            writeIdEx  = 1'b0;
            writeExMem = 1'b0;
            writeMemWb = 1'b0;
            halted     = 1'b1;
        end else if (frozen) begin
            writePc    = 1'b0;
            writeIfId  = 1'b0;
            writeIdEx  = 1'b0;
            writeExMem = 1'b0;
            writeMemWb = 1'b0;
        end else begin
            if (iStalled) begin
                writePc   = 1'b0;
                flushIfId = 1'b1;
                if (loadHazard) begin
                    writeIfId       = 1'b0;
                    controlZeroIdEx = 1'b1;
                end
            end else if (loadHazard) begin
                writePc         = 1'b0;
                writeIfId       = 1'b0;
                controlZeroIdEx = 1'b1;
            end
            if (discard && iMemDone) begin
                flushIfId = 1'b1;
            end
            if (redirectExMem) begin
                writePc         = 1'b1;
                writeIfId       = 1'b1;
                flushIfId       = 1'b1;
                controlZeroIdEx = 1'b1;
            end
        end
    end

    assign ctrlState = state;
    assign countEn   = !writePc && !halted;

    sat_counter #(
        .W(CNT_W)
    ) uStallCnt (
        .clk   (clk),
        .clrN  (rst_n),
        .en    (countEn),
        .count (stallCycles)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: hand-computed expectations for load
// hazard, data/instruction stalls, redirect, async reset and halt.
module tb_pipe_stall_ctrl;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             loadHazard, iMemStall, iMemDone, dMemStall, dMemDone;
    logic             redirectExMem, haltMemWb;
    logic             writePc, writeIfId, writeIdEx, writeExMem, writeMemWb;
    logic             flushIfId, controlZeroIdEx, halted;
    logic [1:0]       ctrlState;
    logic [CNT_W-1:0] stallCycles;
    logic [4:0]       writes;

    int checks = 0;
    int errors = 0;

    pipe_stall_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .loadHazard      (loadHazard),
        .iMemStall       (iMemStall),
        .iMemDone        (iMemDone),
        .dMemStall       (dMemStall),
        .dMemDone        (dMemDone),
        .redirectExMem   (redirectExMem),
        .haltMemWb       (haltMemWb),
        .writePc         (writePc),
        .writeIfId       (writeIfId),
        .writeIdEx       (writeIdEx),
        .writeExMem      (writeExMem),
        .writeMemWb      (writeMemWb),
        .flushIfId       (flushIfId),
        .controlZeroIdEx (controlZeroIdEx),
        .halted          (halted),
        .ctrlState       (ctrlState),
        .stallCycles     (stallCycles)
    );

    // Free-running pipeline clock
    always #5 clk = ~clk;

    assign writes = {writePc, writeIfId, writeIdEx, writeExMem, writeMemWb};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, then settle
    task automatic applyStimulus(input logic lh, input logic iS, input logic iD,
                                 input logic dS, input logic dD, input logic rd, input logic hl);
        @(negedge clk);
        loadHazard    = lh;
        iMemStall     = iS;
        iMemDone      = iD;
        dMemStall     = dS;
        dMemDone      = dD;
        redirectExMem = rd;
        haltMemWb     = hl;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        loadHazard = 0; iMemStall = 0; iMemDone = 0; dMemStall = 0;
        dMemDone = 0; redirectExMem = 0; haltMemWb = 0;
        #2;
        checkOutput("rstWrites", writes, 5'b00000);
        checkOutput("rstFlush", flushIfId, 1'b0);
        checkOutput("rstCz", controlZeroIdEx, 1'b0);
        checkOutput("rstState", ctrlState, 2'd0);
        checkOutput("rstCount", stallCycles, 0);
        checkOutput("rstHalted", halted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("runWrites", writes, 5'b11111);

        // Load hazard
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("lhWrites", writes, 5'b00111);
        checkOutput("lhCz", controlZeroIdEx, 1'b1);
        checkOutput("lhFlush", flushIfId, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("lhCount", stallCycles, 1);
        checkOutput("lhState", ctrlState, 2'd0);

        // Data stall for three cycles then done
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("ds1Writes", writes, 5'b00000);
        checkOutput("ds1State", ctrlState, 2'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("ds2State", ctrlState, 2'd1);
        checkOutput("ds2Writes", writes, 5'b00000);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("ds3State", ctrlState, 2'd1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("dsDoneState", ctrlState, 2'd1);
        checkOutput("dsDoneWrites", writes, 5'b00000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("dsExitState", ctrlState, 2'd0);
        checkOutput("dsCount", stallCycles, 5);
        checkOutput("dsExitWrites", writes, 5'b11111);

        // Overlapping instruction and data stalls
        applyStimulus(0, 1, 0, 1, 0, 0, 0);
        checkOutput("ovWrites", writes, 5'b00000);
        checkOutput("ovFlush", flushIfId, 1'b0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("ovDwait", ctrlState, 2'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("ovIwait", ctrlState, 2'd2);
        checkOutput("ovIwWrites", writes, 5'b01111);
        checkOutput("ovIwFlush", flushIfId, 1'b1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("ovDoneState", ctrlState, 2'd2);
        checkOutput("ovDoneFlush", flushIfId, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("ovExitState", ctrlState, 2'd0);
        checkOutput("ovCount", stallCycles, 9);

        // Redirect during an instruction stall
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("rdEntryWrites", writes, 5'b01111);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rdIw1State", ctrlState, 2'd2);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("rdFlush", flushIfId, 1'b1);
        checkOutput("rdCz", controlZeroIdEx, 1'b1);
        checkOutput("rdWrites", writes, 5'b11111);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rdIw3Writes", writes, 5'b01111);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("rdDoneFlush", flushIfId, 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rdExitState", ctrlState, 2'd0);
        checkOutput("rdExitFlush", flushIfId, 1'b0);
        checkOutput("rdCount", stallCycles, 13);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("discardCleared", flushIfId, 1'b0);

        // Async reset in the middle of a data stall
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("arDwait", ctrlState, 2'd1);
        @(negedge clk);
        dMemStall = 1'b0;
        checkOutput("arPreCount", stallCycles, 15);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arState", ctrlState, 2'd0);
        checkOutput("arCount", stallCycles, 0);
        checkOutput("arWrites", writes, 5'b00000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("arRelWrites", writes, 5'b11111);
        checkOutput("arRelState", ctrlState, 2'd0);

        // Halt freezes everything until reset
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("hPreCount", stallCycles, 1);
        checkOutput("hPreState", ctrlState, 2'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("hState", ctrlState, 2'd3);
        checkOutput("hHalted", halted, 1'b1);
        checkOutput("hWrites", writes, 5'b00000);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("hDsState", ctrlState, 2'd3);
        checkOutput("hDsWrites", writes, 5'b00000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("hCount", stallCycles, 1);
        checkOutput("hStay", ctrlState, 2'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It merges the load-use hazard indication, multi-cycle instruction- and data-memory stalls, taken-branch redirects and halt into one consistent set of per-stage write enables and bubble controls. It sits beside the hazard unit and drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A small FSM tracks outstanding memory stalls, and a saturating counter reports lost cycles.

## Interface
Parameters:
- CNT_W, 16, width of stall-cycle counter

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  reset, asynchronous, active-low
- loadHazard  in  1  load-use hazard from hazard unit (ID/EX load feeds IF/ID source)
- iMemStall  in  1  instruction memory not ready this cycle
- iMemDone  in  1  instruction memory returns fetch this cycle
- dMemStall  in  1  data memory not ready (EX/MEM access)
- dMemDone  in  1  data memory completes this cycle
- redirectExMem  in  1  taken branch/jump resolved, wrong-path flush required
- haltMemWb  in  1  HALT instruction reaching MEM/WB
- writePc, writeIfId, writeIdEx, writeExMem, writeMemWb  out  1 each  register write enables
- flushIfId  out  1  load NOP into IF/ID
- controlZeroIdEx  out  1  zero control bits entering ID/EX
- halted  out  1  pipeline frozen by HALT
- ctrlState  out  2  current FSM state
- stallCycles  out  CNT_W  saturating count of cycles with writePc=0 while not halted

## Operation
- States: RUN=0, DWAIT=1, IWAIT=2, HALT=3.
- RUN transitions, by priority: haltMemWb -> HALT; dMemStall -> DWAIT; iMemStall -> IWAIT; otherwise RUN.
- DWAIT transitions: dMemDone -> IWAIT if iPend is set, else RUN. Otherwise remain in DWAIT.
- IWAIT transitions: dMemStall -> DWAIT and set iPend; iMemDone -> RUN; otherwise remain.
- HALT is left only by reset.
- iPend: sticky flag meaning the fetch is still outstanding. It is set on the IWAIT->DWAIT transition and cleared on iMemDone in any state. If iMemDone arrives while in DWAIT, clear iPend; DWAIT then exits to RUN.
- discard: sticky flag, set by redirectExMem while in IWAIT or while iPend is set. On the next iMemDone, discard forces flushIfId=1 and discard is cleared.
- Outputs per state; enables are 1 unless listed:
  - DWAIT, or RUN with dMemStall: all five writes are 0. flushIfId=0 and controlZeroIdEx=0. The whole pipe freezes.
  - IWAIT, or RUN with iMemStall: writePc=0 and writeIfId=1 with flushIfId=1, so a bubble enters. ID and later stages advance, except that loadHazard still sets controlZeroIdEx=1 and writeIfId=0.
  - RUN with loadHazard: writePc=0, writeIfId=0, controlZeroIdEx=1.
  - redirectExMem, when not frozen by a data stall: writePc=1, flushIfId=1, controlZeroIdEx=1. This overrides loadHazard.
  - HALT: all writes 0, halted=1.
- stallCycles increments when writePc=0 and halted=0. It saturates at all-ones.

## Timing
- All stage controls are combinational (Mealy) from state, flags and current inputs, with zero latency. State, flags and counter update on posedge clk.
- Reset values: state RUN, iPend=0, discard=0, stallCycles=0, halted=0.
- While rst_n=0 all write enables are forced to 0, and flushIfId and controlZeroIdEx are forced to 0.
- Reset assertion mid-stall clears everything immediately. It does not wait for the clock edge.
- dMemStall and iMemStall in the same RUN cycle: the data stall wins. iPend is set on entry to DWAIT.
- dMemDone and dMemStall in the same cycle: treat as done. dMemStall must drop the cycle after.
- Stall+done in the same cycle in IWAIT: done wins and the next state is RUN.
- haltMemWb while in DWAIT is ignored until RUN is reached.

## Structure
- Shared constants file holds the state encodings RUN/DWAIT/IWAIT/HALT (2-bit). These are reused by the trace/debug monitor.
- One sub-module, sat_counter (width parameter, enable, async active-low clear), implements stallCycles.
- The FSM, flags and output decode stay in pipe_stall_ctrl.

## Test plan
- Load hazard only: loadHazard=1 for 1 cycle in RUN -> writePc=0, writeIfId=0, controlZeroIdEx=1 in that cycle; stallCycles goes 0->1.
- Data stall: dMemStall held for 3 cycles, then dMemDone -> ctrlState=1 for 3 cycles, all writes 0, then RUN; stallCycles=4.
- Overlap: iMemStall and dMemStall in the same cycle -> DWAIT. On dMemDone -> IWAIT (iPend=1). On iMemDone -> RUN, with flushIfId=1 in each IWAIT cycle.
- Redirect during IWAIT: redirectExMem=1 at IWAIT cycle 2 -> flushIfId=1 and controlZeroIdEx=1 that cycle. At the later iMemDone cycle flushIfId=1 again, and discard clears.
- Halt: haltMemWb=1 in RUN -> next cycle ctrlState=3, halted=1, all writes 0, stallCycles frozen. A later dMemStall has no effect.
- Async reset mid-DWAIT: drop rst_n between clock edges -> ctrlState=0 and stallCycles=0 immediately, enables 0. After release with no stalls, writes are all 1.
